ctrl_sequencer: RTL and testbench

//  Control sequencer of the small model computer, directly downstream of the instruction decoder.
//  - Drives the decoder enable and registers its 12 one-hot outputs.
//  - Steps FETCH/DECODE/EXEC/WAIT/HALT and emits per-cycle strobes to PC, IR, register file, ALU, flags and I/O.
//  - Handles I/O handshakes and conditional jumps.

---
 rtl/ctrl_sequencer_if.sv | 50 +++++
 rtl/ctrl_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_sequencer_if.sv
// Signal bundle between the control sequencer (master) and the decoder/datapath (slave).
// instr_cnt and its CNT_W parameter exist only when PERF_CNT_EN is defined.
interface ctrl_sequencer_if
`ifdef PERF_CNT_EN
  #(parameter int CNT_W = 16)
`endif
  ;
  logic mova, movb, movc, movd, movi, add, sub, jmp, jg, in1, out1, halt;
  logic flag_g;
  logic in_valid;
  logic out_ready;

  logic       dec_en;
  logic       ir_ld;
  logic       pc_inc;
  logic       pc_ld;
  logic       rf_we;
  logic [1:0] rf_src;
  logic       alu_sub;
  logic       flag_ld;
  logic       out_ld;
  logic       in_ack;
  logic       illegal;
  logic       io_timeout;
  logic       halted;
  logic [2:0] state;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] instr_cnt;
`endif

  modport master (
    input  mova, movb, movc, movd, movi, add, sub, jmp, jg, in1, out1, halt,
    input  flag_g, in_valid, out_ready,
    output dec_en, ir_ld, pc_inc, pc_ld, rf_we, rf_src, alu_sub, flag_ld,
    output out_ld, in_ack, illegal, io_timeout, halted, state
`ifdef PERF_CNT_EN
    , output instr_cnt
`endif
  );

  modport slave (
    output mova, movb, movc, movd, movi, add, sub, jmp, jg, in1, out1, halt,
    output flag_g, in_valid, out_ready,
    input  dec_en, ir_ld, pc_inc, pc_ld, rf_we, rf_src, alu_sub, flag_ld,
    input  out_ld, in_ack, illegal, io_timeout, halted, state
`ifdef PERF_CNT_EN
    , input instr_cnt
`endif
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Control sequencer: FETCH/DECODE/EXEC/WAIT/HALT stepping with per-cycle datapath strobes.
// Define PERF_CNT_EN to add the retired-instruction counter output instr_cnt.
module ctrl_sequencer #(
  parameter int WAIT_TMO = 0,
  parameter int TMO_W    = 8
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  ctrl_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_WAIT_IN  = 3'd3,
    S_WAIT_OUT = 3'd4,
    S_HALT     = 3'd5
  } state_e;

  localparam int OP_MOVA = 11;
  localparam int OP_MOVB = 10;
  localparam int OP_MOVC = 9;
  localparam int OP_MOVD = 8;
  localparam int OP_MOVI = 7;
  localparam int OP_ADD  = 6;
  localparam int OP_SUB  = 5;
  localparam int OP_JMP  = 4;
  localparam int OP_JG   = 3;
  localparam int OP_IN1  = 2;
  localparam int OP_OUT1 = 1;
  localparam int OP_HALT = 0;

  state_e           state_q, state_d;
  logic [11:0]      op_q, op_d;
  logic [TMO_W-1:0] wcnt_q, wcnt_d;

  logic [11:0] dec_in;
  logic        dec_legal;
  logic        wait_in_hs;
  logic        wait_out_hs;
  logic        tmo_hit;
  logic        unused_wait_ops;

  assign dec_in = {bus.mova, bus.movb, bus.movc, bus.movd, bus.movi, bus.add,
                   bus.sub, bus.jmp, bus.jg, bus.in1, bus.out1, bus.halt};
  assign dec_legal = $onehot(dec_in);

  // Handshake: in_valid / out_ready are level signals owned by the ports. A transfer
  // happens in any cycle the sequencer sits in the matching wait state with the line
  // high; in_ack (with the register write) or out_ld pulses in that same cycle.
  assign wait_in_hs  = (state_q == S_WAIT_IN)  && bus.in_valid;
  assign wait_out_hs = (state_q == S_WAIT_OUT) && bus.out_ready;
  assign tmo_hit     = (WAIT_TMO != 0) && (wcnt_q == TMO_W'(WAIT_TMO - 1));

  // The wait and halt states already identify these opcodes.
  assign unused_wait_ops = op_q[OP_IN1] | op_q[OP_OUT1] | op_q[OP_HALT];

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    wcnt_d         = wcnt_q;
    bus.dec_en     = 1'b0;
    bus.ir_ld      = 1'b0;
    bus.pc_inc     = 1'b0;
    bus.pc_ld      = 1'b0;
    bus.rf_we      = 1'b0;
    bus.rf_src     = 2'b00;
    bus.alu_sub    = 1'b0;
    bus.flag_ld    = 1'b0;
    bus.out_ld     = 1'b0;
    bus.in_ack     = 1'b0;
    bus.illegal    = 1'b0;
    bus.io_timeout = 1'b0;
    bus.halted     = 1'b0;
    bus.state      = 3'd0;
    if (!rst) begin
      bus.state = state_q;
      case (state_q)
        S_FETCH: begin
          bus.ir_ld  = 1'b1;
          bus.pc_inc = 1'b1;
          state_d    = S_DECODE;
        end
        S_DECODE: begin
          bus.dec_en = 1'b1;
          op_d       = dec_in;
          wcnt_d     = '0;
          if (!dec_legal) begin
            bus.illegal = 1'b1;
            state_d     = S_FETCH;
          end else if (dec_in[OP_HALT]) begin
            state_d = S_HALT;
          end else if (dec_in[OP_IN1]) begin
            state_d = S_WAIT_IN;
          end else if (dec_in[OP_OUT1]) begin
            state_d = S_WAIT_OUT;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          state_d = S_FETCH;
          if (op_q[OP_MOVA] | op_q[OP_MOVB] | op_q[OP_MOVC] | op_q[OP_MOVD]) begin
            bus.rf_we = 1'b1;
          end
          if (op_q[OP_MOVI]) begin
            bus.rf_we  = 1'b1;
            bus.rf_src = 2'b10;
            bus.pc_inc = 1'b1;
          end
          if (op_q[OP_ADD] | op_q[OP_SUB]) begin
            bus.rf_we   = 1'b1;
            bus.rf_src  = 2'b01;
            bus.flag_ld = 1'b1;
            bus.alu_sub = op_q[OP_SUB];
          end
          if (op_q[OP_JMP]) begin
            bus.pc_ld = 1'b1;
          end
          if (op_q[OP_JG]) begin
            bus.pc_ld  = bus.flag_g;
            bus.pc_inc = !bus.flag_g;
          end
        end
        S_WAIT_IN, S_WAIT_OUT: begin
          // A handshake in the timeout cycle wins over the timeout.
          if (wait_in_hs) begin
            bus.rf_we  = 1'b1;
            bus.rf_src = 2'b11;
            bus.in_ack = 1'b1;
            state_d    = S_FETCH;
          end else if (wait_out_hs) begin
            bus.out_ld = 1'b1;
            state_d    = S_FETCH;
          end else if (tmo_hit) begin
            bus.io_timeout = 1'b1;
            state_d        = S_FETCH;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        S_HALT: begin
          bus.halted = 1'b1;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wcnt_q  <= wcnt_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_ev;

  assign cnt_ev = (state_q == S_EXEC) || wait_in_hs || wait_out_hs ||
                  ((state_q == S_DECODE) && dec_legal && dec_in[OP_HALT]);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_ev) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.instr_cnt = rst ? '0 : cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: two instances (WAIT_TMO=0 and WAIT_TMO=4), an instruction-level
// expectation model feeding an expected queue, plus literal pins on key cycles.
module tb_ctrl_sequencer;
  localparam int CNT_W = 16;
  localparam int W     = 17 + CNT_W;

  localparam logic [11:0] OP_MOVA = 12'h800, OP_MOVB = 12'h400, OP_MOVC = 12'h200;
  localparam logic [11:0] OP_MOVD = 12'h100, OP_MOVI = 12'h080, OP_ADD  = 12'h040;
  localparam logic [11:0] OP_SUB  = 12'h020, OP_JMP  = 12'h010, OP_JG   = 12'h008;
  localparam logic [11:0] OP_IN1  = 12'h004, OP_OUT1 = 12'h002, OP_HALT = 12'h001;

  localparam logic [13:0] X_DEC = 14'h2000, X_IRLD = 14'h1000, X_PCINC = 14'h0800;
  localparam logic [13:0] X_PCLD = 14'h0400, X_RFWE = 14'h0200, X_SRC_ALU = 14'h0080;
  localparam logic [13:0] X_SRC_IMM = 14'h0100, X_SRC_IN = 14'h0180, X_SUB = 14'h0040;
  localparam logic [13:0] X_FLAG = 14'h0020, X_OUTLD = 14'h0010, X_INACK = 14'h0008;
  localparam logic [13:0] X_ILL = 14'h0004, X_TMO = 14'h0002, X_HALT = 14'h0001;

  // Hand-computed output words: {state, dec_en, ir_ld, pc_inc, pc_ld, rf_we, rf_src,
  // alu_sub, flag_ld, out_ld, in_ack, illegal, io_timeout, halted}.
  localparam logic [16:0] L_ZERO   = 17'b000_0_0_0_0_0_00_0_0_0_0_0_0_0;
  localparam logic [16:0] L_FETCH  = 17'b000_0_1_1_0_0_00_0_0_0_0_0_0_0;
  localparam logic [16:0] L_MOVI   = 17'b010_0_0_1_0_1_10_0_0_0_0_0_0_0;
  localparam logic [16:0] L_ADD    = 17'b010_0_0_0_0_1_01_0_1_0_0_0_0_0;
  localparam logic [16:0] L_SUB    = 17'b010_0_0_0_0_1_01_1_1_0_0_0_0_0;
  localparam logic [16:0] L_JG_T   = 17'b010_0_0_0_1_0_00_0_0_0_0_0_0_0;
  localparam logic [16:0] L_JG_N   = 17'b010_0_0_1_0_0_00_0_0_0_0_0_0_0;
  localparam logic [16:0] L_IN_ACK = 17'b011_0_0_0_0_1_11_0_0_0_1_0_0_0;
  localparam logic [16:0] L_OUT_LD = 17'b100_0_0_0_0_0_00_0_0_1_0_0_0_0;
  localparam logic [16:0] L_TMO    = 17'b100_0_0_0_0_0_00_0_0_0_0_0_1_0;
  localparam logic [16:0] L_ILL    = 17'b001_1_0_0_0_0_00_0_0_0_0_1_0_0;
  localparam logic [16:0] L_HALTED = 17'b101_0_0_0_0_0_00_0_0_0_0_0_0_1;

  typedef struct packed {
    int          d;
    int          id;
    int          cyc;
    logic [W-1:0] mask;
    logic [W-1:0] val;
  } pin_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1;
  logic [11:0] dec0, dec1;
  logic        fg0, fg1, iv0, iv1, or0, or1;
  logic [W-1:0] obs0, obs1;

  ctrl_sequencer_if
`ifdef PERF_CNT_EN
    #(.CNT_W(CNT_W))
`endif
    if0 ();
  ctrl_sequencer_if
`ifdef PERF_CNT_EN
    #(.CNT_W(CNT_W))
`endif
    if1 ();

  ctrl_sequencer #(
    .WAIT_TMO(0), .TMO_W(8)
`ifdef PERF_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut0 (.clk(clk), .rst(rst0), .bus(if0.master));

  ctrl_sequencer #(
    .WAIT_TMO(4), .TMO_W(8)
`ifdef PERF_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut1 (.clk(clk), .rst(rst1), .bus(if1.master));

  assign {if0.mova, if0.movb, if0.movc, if0.movd, if0.movi, if0.add, if0.sub,
          if0.jmp, if0.jg, if0.in1, if0.out1, if0.halt} = dec0;
  assign {if1.mova, if1.movb, if1.movc, if1.movd, if1.movi, if1.add, if1.sub,
          if1.jmp, if1.jg, if1.in1, if1.out1, if1.halt} = dec1;
  assign if0.flag_g = fg0;  assign if0.in_valid = iv0;  assign if0.out_ready = or0;
  assign if1.flag_g = fg1;  assign if1.in_valid = iv1;  assign if1.out_ready = or1;

  assign obs0[16:0] = {if0.state, if0.dec_en, if0.ir_ld, if0.pc_inc, if0.pc_ld, if0.rf_we,
                       if0.rf_src, if0.alu_sub, if0.flag_ld, if0.out_ld, if0.in_ack,
                       if0.illegal, if0.io_timeout, if0.halted};
  assign obs1[16:0] = {if1.state, if1.dec_en, if1.ir_ld, if1.pc_inc, if1.pc_ld, if1.rf_we,
                       if1.rf_src, if1.alu_sub, if1.flag_ld, if1.out_ld, if1.in_ack,
                       if1.illegal, if1.io_timeout, if1.halted};
`ifdef PERF_CNT_EN
  assign obs0[W-1:17] = if0.instr_cnt;
  assign obs1[W-1:17] = if1.instr_cnt;
`else
  assign obs0[W-1:17] = '0;
  assign obs1[W-1:17] = '0;
`endif

  // scoreboard state
  logic [2*W-1:0] exp_q[$];
  pin_t           pin_q[$];
  int             applied_cyc = 0;
  int             cmp_cyc = 0;
  int             vectors = 0;
  int             errors = 0;
  int             cnt_m[2];
  bit             pin_fetch = 1'b0;

  function automatic int tmo_of(input int d);
    return (d == 1) ? 4 : 0;
  endfunction

  function automatic logic [W-1:0] ev(input int d, input int st, input logic [13:0] s);
    logic [CNT_W-1:0] c;
`ifdef PERF_CNT_EN
    c = CNT_W'(cnt_m[d]);
`else
    c = '0;
`endif
    return {c, 3'(st), s};
  endfunction

  function automatic logic [13:0] exec_strobes(input logic [11:0] op, input bit fg);
    case (op)
      OP_MOVA, OP_MOVB, OP_MOVC, OP_MOVD: return X_RFWE;
      OP_MOVI: return X_RFWE | X_SRC_IMM | X_PCINC;
      OP_ADD:  return X_RFWE | X_SRC_ALU | X_FLAG;
      OP_SUB:  return X_RFWE | X_SRC_ALU | X_FLAG | X_SUB;
      OP_JMP:  return X_PCLD;
      OP_JG:   return fg ? X_PCLD : X_PCINC;
      default: return 14'h0;
    endcase
  endfunction

  function automatic string pin_name(input int id);
    case (id)
      1: return "rst_all_zero";
      2: return "first_fetch";
      3: return "movi_exec";
      4: return "add_exec";
      5: return "sub_exec";
      6: return "jg_taken";
      7: return "jg_not_taken";
      8: return "in_ack_6th_wait";
      9: return "illegal_zero";
      10: return "illegal_multi";
      11: return "halt_held_cnt";
      12: return "out_timeout_4th";
      13: return "in_hs_beats_tmo";
      14: return "out_hs_beats_tmo";
      15: return "out_ld_wait";
      default: return "pin";
    endcase
  endfunction

  // driver: one call = one clock cycle; the idle instance is held in reset
  task automatic apply(input int d, input bit r, input logic [11:0] dec, input bit fg,
                       input bit iv, input bit orr, input logic [W-1:0] e);
    @(posedge clk);
    #1;
    if (d == 0) begin
      rst0 = r; dec0 = dec; fg0 = fg; iv0 = iv; or0 = orr;
      rst1 = 1'b1; dec1 = '0; fg1 = 1'b0; iv1 = 1'b0; or1 = 1'b0;
      exp_q.push_back({{W{1'b0}}, e});
    end else begin
      rst1 = r; dec1 = dec; fg1 = fg; iv1 = iv; or1 = orr;
      rst0 = 1'b1; dec0 = '0; fg0 = 1'b0; iv0 = 1'b0; or0 = 1'b0;
      exp_q.push_back({e, {W{1'b0}}});
    end
    applied_cyc++;
  endtask

  task automatic pin_last(input int d, input int id, input logic [16:0] v,
                          input bit with_cnt, input int cnt);
    pin_t p;
    p.d    = d;
    p.id   = id;
    p.cyc  = applied_cyc - 1;
    p.val  = {CNT_W'(cnt), v};
    p.mask = with_cnt ? {W{1'b1}} : {{CNT_W{1'b0}}, 17'h1FFFF};
    pin_q.push_back(p);
  endtask

  task automatic do_reset(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      cnt_m[d] = 0;
      apply(d, 1'b1, 12'hFFF, 1'b1, 1'b1, 1'b1, '0);
    end
  endtask

  // one instruction: FETCH, DECODE, then EXEC or the I/O wait (stall = cycles the line stays low)
  task automatic run_instr(input int d, input logic [11:0] op, input bit fg, input int stall,
                           input int pid, input logic [16:0] pv);
    bit legal;
    bit is_in;
    bit hs;
    apply(d, 1'b0, 12'h0, !fg, 1'b0, 1'b0, ev(d, 0, X_IRLD | X_PCINC));
    if (pin_fetch) begin
      pin_last(d, 2, L_FETCH, 1'b0, 0);
      pin_fetch = 1'b0;
    end
    legal = ($countones(op) == 1);
    apply(d, 1'b0, op, !fg, 1'b0, 1'b0, ev(d, 1, legal ? X_DEC : (X_DEC | X_ILL)));
    if (!legal || op == OP_HALT) begin
      if (legal) cnt_m[d]++;
    end else if (op == OP_IN1 || op == OP_OUT1) begin
      is_in = (op == OP_IN1);
      for (int k = 0; k <= stall; k++) begin
        hs = (k == stall);
        if (hs) begin
          apply(d, 1'b0, 12'h0, fg, is_in ? 1'b1 : 1'b1, 1'b1,
                ev(d, is_in ? 3 : 4, is_in ? (X_RFWE | X_SRC_IN | X_INACK) : X_OUTLD));
          cnt_m[d]++;
        end else if (tmo_of(d) != 0 && k == tmo_of(d) - 1) begin
          apply(d, 1'b0, 12'h0, fg, !is_in, is_in, ev(d, is_in ? 3 : 4, X_TMO));
          break;
        end else begin
          apply(d, 1'b0, 12'h0, fg, !is_in, is_in, ev(d, is_in ? 3 : 4, 14'h0));
        end
      end
    end else begin
      apply(d, 1'b0, 12'h0, fg, 1'b0, 1'b0, ev(d, 2, exec_strobes(op, fg)));
      cnt_m[d]++;
    end
    if (pid != 0) pin_last(d, pid, pv, 1'b0, 0);
  endtask

  task automatic halt_idle(input int d, input int n);
    for (int i = 0; i < n; i++) apply(d, 1'b0, 12'hFFF, 1'b1, 1'b1, 1'b1, ev(d, 5, X_HALT));
  endtask

  // compare process
  initial begin
    logic [2*W-1:0] e;
    logic [W-1:0]   act;
    logic [W-1:0]   ex;
    pin_t           p;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int d = 0; d < 2; d++) begin
          act = (d == 1) ? obs1 : obs0;
          ex  = e[d*W +: W];
          vectors++;
          if (act !== ex) begin
            errors++;
            $display("FAIL model dut%0d cycle %0d: got %h required %h", d, cmp_cyc, act, ex);
          end
        end
        while (pin_q.size() > 0 && pin_q[0].cyc == cmp_cyc) begin
          p   = pin_q.pop_front();
          act = ((p.d == 1) ? obs1 : obs0) & p.mask;
          vectors++;
          if (act !== (p.val & p.mask)) begin
            errors++;
            $display("FAIL %s dut%0d: got %h required %h", pin_name(p.id), p.d, act,
                     p.val & p.mask);
          end
        end
        cmp_cyc++;
      end
    end
  end

  // directed stimulus
  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    dec0 = '0; dec1 = '0; fg0 = 1'b0; fg1 = 1'b0;
    iv0 = 1'b0; iv1 = 1'b0; or0 = 1'b0; or1 = 1'b0;
    cnt_m[0] = 0; cnt_m[1] = 0;

    // WAIT_TMO = 0 instance
    do_reset(0, 2);
    pin_last(0, 1, L_ZERO, 1'b1, 0);
    pin_fetch = 1'b1;
    run_instr(0, OP_MOVI, 1'b0, 0, 3, L_MOVI);
    run_instr(0, OP_ADD,  1'b0, 0, 4, L_ADD);
    run_instr(0, OP_SUB,  1'b1, 0, 5, L_SUB);
    run_instr(0, OP_MOVA, 1'b0, 0, 0, L_ZERO);
    run_instr(0, OP_MOVB, 1'b1, 0, 0, L_ZERO);
    run_instr(0, OP_MOVC, 1'b0, 0, 0, L_ZERO);
    run_instr(0, OP_MOVD, 1'b1, 0, 0, L_ZERO);
    run_instr(0, OP_JG,   1'b1, 0, 6, L_JG_T);
    run_instr(0, OP_JG,   1'b0, 0, 7, L_JG_N);
    run_instr(0, OP_JMP,  1'b0, 0, 0, L_ZERO);
    run_instr(0, OP_IN1,  1'b0, 5, 8, L_IN_ACK);
    run_instr(0, OP_OUT1, 1'b0, 0, 0, L_ZERO);
    run_instr(0, OP_OUT1, 1'b1, 2, 15, L_OUT_LD);
    run_instr(0, 12'h000, 1'b0, 0, 9, L_ILL);
    run_instr(0, OP_MOVA | OP_ADD, 1'b0, 0, 10, L_ILL);
    run_instr(0, OP_MOVB, 1'b0, 0, 0, L_ZERO);

    // retired count, halt hold, reset out of HALT
    do_reset(0, 2);
    run_instr(0, OP_MOVA, 1'b0, 0, 0, L_ZERO);
    run_instr(0, 12'h000, 1'b0, 0, 0, L_ZERO);
    run_instr(0, OP_JMP,  1'b0, 0, 0, L_ZERO);
    run_instr(0, OP_IN1,  1'b0, 1, 0, L_ZERO);
    run_instr(0, OP_HALT, 1'b0, 0, 0, L_ZERO);
    halt_idle(0, 20);
`ifdef PERF_CNT_EN
    pin_last(0, 11, L_HALTED, 1'b1, 4);
`else
    pin_last(0, 11, L_HALTED, 1'b0, 0);
`endif
    do_reset(0, 1);
    pin_last(0, 1, L_ZERO, 1'b1, 0);
    pin_fetch = 1'b1;
    run_instr(0, OP_MOVC, 1'b0, 0, 0, L_ZERO);

    // WAIT_TMO = 4 instance
    do_reset(1, 2);
    run_instr(1, OP_OUT1, 1'b0, 100, 12, L_TMO);
    run_instr(1, OP_IN1,  1'b0, 3, 13, L_IN_ACK);
    run_instr(1, OP_OUT1, 1'b0, 3, 14, L_OUT_LD);
    run_instr(1, OP_IN1,  1'b1, 0, 0, L_ZERO);
    run_instr(1, OP_IN1,  1'b1, 9, 0, L_ZERO);
    run_instr(1, OP_MOVI, 1'b0, 0, 3, L_MOVI);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
